// File: rtl/reg_pkg.sv
// Operation encodings for the universal register, shared with any controller
// that drives its mode input.
package reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

endpackage

// File: rtl/univ_register.sv
// N-bit universal register: hold, load, shift, rotate, increment and decrement,
// with a registered carry/shift-out bit and a combinational zero flag.
module univ_register
    import reg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [2:0]   mode,
    input  logic [N-1:0] d,
    input  logic         sin_r,
    input  logic         sin_l,
    output logic [N-1:0] q,
    output logic         co,
    output logic         zero
);

    localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

    logic [N-1:0] q_nxt;
    logic         co_nxt;
    logic [N:0]   sum;
    logic [N:0]   diff;

    // Arithmetic is done one bit wider so bit N carries the wrap (INC) or
    // the borrow (DEC) directly.
    assign sum  = {1'b0, q} + ONE;
    assign diff = {1'b0, q} - ONE;

    always_comb begin
        q_nxt  = q;
        co_nxt = co;
        case (mode)
            MODE_HOLD: begin
                q_nxt  = q;
                co_nxt = co;
            end
            MODE_LOAD: begin
                q_nxt  = d;
                co_nxt = 1'b0;
            end
            MODE_SHL: begin
                q_nxt  = {q[N-2:0], sin_r};
                co_nxt = q[N-1];
            end
            MODE_SHR: begin
                q_nxt  = {sin_l, q[N-1:1]};
                co_nxt = q[0];
            end
            MODE_ROL: begin
                q_nxt  = {q[N-2:0], q[N-1]};
                co_nxt = q[N-1];
            end
            MODE_ROR: begin
                q_nxt  = {q[0], q[N-1:1]};
                co_nxt = q[0];
            end
            MODE_INC: begin
                q_nxt  = sum[N-1:0];
                co_nxt = sum[N];
            end
            MODE_DEC: begin
                q_nxt  = diff[N-1:0];
                co_nxt = diff[N];
            end
            default: begin
                q_nxt  = q;
                co_nxt = co;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q  <= '0;
            co <= 1'b0;
        end else begin
            q  <= q_nxt;
            co <= co_nxt;
        end
    end

    assign zero = (q == '0);

endmodule
